// File: rtl/disp7_pkg.sv
// Shared types and the hex-to-segment pattern table for the multiplexed display driver.
// Segment encoding is active-low with seg[6:0] = g..a and seg[7] = dp.
package disp7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  // Returns the digit pattern with the decimal point dark.
  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t s;
    s = SEG_OFF;
    case (nibble)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/disp7_hex_decoder.sv
// Combinational digit renderer: nibble plus decimal point, with blank forcing the digit dark.
module disp7_hex_decoder
  import disp7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o    = hex_to_seg(nibble_i);
    seg_o[7] = ~dp_i;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end
  end

endmodule

// File: rtl/disp7_mux_param.sv
// N-digit multiplexed seven-segment driver with double-buffered writes, blanking,
// leading-zero suppression and PWM brightness. Outputs are registered one cycle behind the scan.
module disp7_mux_param
  import disp7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned SCAN_DIV = 10000,
  parameter int unsigned BRIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [N_DIGITS-1:0]   an,
  output seg_t                  seg,
  output logic                  pend,
  output logic                  frame_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DigW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [DigW-1:0] DigMax = DigW'(N_DIGITS - 1);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic                  lz;
  } disp_buf_t;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DigW-1:0]     dig_q, dig_d;
  disp_buf_t           stage_q, stage_d;
  disp_buf_t           shadow_q, shadow_d;
  logic                pend_q, pend_d;
  logic                tick_q, tick_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  seg_t                seg_q, seg_d;

  logic                frame_end;
  logic [31:0]         duty;
  logic                lit;
  logic [3:0]          nibble_cur;
  logic                dp_cur;
  logic                blank_cur;
  logic                supp_cur;
  logic                zero_run;
  logic [N_DIGITS-1:0] one_hot;
  seg_t                dec_seg;
  seg_t                seg_cur;

  // Scan counters and double-buffer handshake.
  always_comb begin
    frame_end = (cnt_q == CntMax) && (dig_q == DigMax);
    cnt_d     = cnt_q + 1'b1;
    dig_d     = dig_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      dig_d = (dig_q == DigMax) ? '0 : dig_q + 1'b1;
    end

    stage_d  = stage_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    if (frame_end && pend_q) begin
      shadow_d = stage_q;
      pend_d   = 1'b0;
      tick_d   = 1'b1;
    end
    // A write on the frame-end cycle lands in staging after the shadow took the old contents.
    if (we) begin
      stage_d = '{data: data_in, dp: dp_in, blank: blank_in, lz: lz_en};
      pend_d  = 1'b1;
    end
  end

  // Select the current digit and work out suppression from the top digit downwards.
  always_comb begin
    nibble_cur = 4'h0;
    dp_cur     = 1'b0;
    blank_cur  = 1'b0;
    supp_cur   = 1'b0;
    one_hot    = '0;
    zero_run   = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_q.data[4*i +: 4] == 4'h0);
      if (DigW'(i) == dig_q) begin
        nibble_cur = shadow_q.data[4*i +: 4];
        dp_cur     = shadow_q.dp[i];
        blank_cur  = shadow_q.blank[i];
        supp_cur   = shadow_q.lz && zero_run && (i != 0);
        one_hot[i] = 1'b1;
      end
    end
  end

  disp7_hex_decoder u_hex_decoder (
    .nibble_i (nibble_cur),
    .dp_i     (dp_cur),
    .blank_i  (blank_cur),
    .seg_o    (dec_seg)
  );

  assign duty = ((32'(bright) + 32'd1) * SCAN_DIV) >> BRIGHT_W;

  always_comb begin
    seg_cur = dec_seg;
    if (supp_cur && !blank_cur) begin
      seg_cur[6:0] = 7'h7F;
    end
    lit   = (32'(cnt_q) < duty);
    an_d  = lit ? ~one_hot : '1;
    seg_d = lit ? seg_cur : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dig_q    <= '0;
      stage_q  <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      stage_q  <= stage_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pend       = pend_q;
  assign frame_tick = tick_q;

endmodule
